// File: rtl/rr_arb_idx.sv
// rr_arb_idx: round-robin arbiter emitting the winner as a binary index with a
// valid/ready handshake. Intended to feed a binary-to-one-hot decoder; idx_o is
// always < NUM_REQ and is held stable while a transfer is stalled.
//
// Parameters:
//   NUM_REQ    number of requesters (>= 1, any value)
//   IDX_WIDTH  derived index width; do not override
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   flush_i  synchronous clear of pointer and lock
//   req_i    request vector, bit i = requester i
//   valid_o  a winner is presented
//   ready_i  downstream accepts the current winner
//   idx_o    binary index of the winner, 0 when valid_o = 0
//
// Optional feature macro: RR_ARB_IDX_ASSERT_EN enables simulation-only protocol
// and invariant checks (excluded under SYNTHESIS). Undefined by default.

module rr_arb_idx #(
    parameter int unsigned NUM_REQ   = 16,
    parameter int unsigned IDX_WIDTH = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [NUM_REQ-1:0]   req_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [IDX_WIDTH-1:0] idx_o
);

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_REQ - 1);

    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic                 lock_q, lock_d;
    logic [IDX_WIDTH-1:0] lock_idx_q, lock_idx_d;

    logic                 any_req;
    logic [IDX_WIDTH-1:0] pick;
    logic                 valid;
    logic [IDX_WIDTH-1:0] idx;

    // Cyclic first-set search starting at ptr_q. The wrap is done on the integer
    // candidate so non-power-of-two sizes never visit codes >= NUM_REQ.
    always_comb begin
        int unsigned          cand;
        logic [IDX_WIDTH-1:0] cand_idx;
        any_req  = 1'b0;
        pick     = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_WIDTH'(cand);
            if (!any_req && req_i[cand_idx]) begin
                any_req = 1'b1;
                pick    = cand_idx;
            end
        end
    end

    // Outputs depend only on state and req_i, never on ready_i.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        if (lock_q) begin
            valid = 1'b1;
            idx   = lock_idx_q;
        end else if (any_req) begin
            valid = 1'b1;
            idx   = pick;
        end
    end

    assign valid_o = valid;
    assign idx_o   = idx;

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (valid && ready_i) begin
            ptr_d  = (idx == LastIdx) ? '0 : idx + IDX_WIDTH'(1);
            lock_d = 1'b0;
        end else if (valid) begin
            // Freeze the presented winner until it is accepted.
            lock_d     = 1'b1;
            lock_idx_d = idx;
        end
        if (flush_i) begin
            ptr_d  = '0;
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

`ifdef RR_ARB_IDX_ASSERT_EN
`ifndef SYNTHESIS
    logic                 stall_prev;
    logic [IDX_WIDTH-1:0] idx_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_prev <= 1'b0;
            idx_prev   <= '0;
        end else begin
            stall_prev <= valid && !ready_i && !flush_i;
            idx_prev   <= idx;
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (int'(ptr_q) >= NUM_REQ) begin
                $fatal(1, "rr_arb_idx: ptr %0d out of range", ptr_q);
            end
            if (lock_q && !req_i[lock_idx_q]) begin
                $fatal(1, "rr_arb_idx: requester %0d withdrew while locked", lock_idx_q);
            end
            if (stall_prev && (idx != idx_prev)) begin
                $fatal(1, "rr_arb_idx: idx changed %0d -> %0d during stall", idx_prev, idx);
            end
        end
    end
`endif
`else
    // Checks compiled out; functional behaviour unchanged.
`endif

endmodule
